// File: rtl/ecg_head_pkg.sv
// Shared types for the ECG classification head: FSM states and derived widths.
package ecg_head_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, DONE} state_e;

  // Column-sum width: wide enough for MATRIX_SIZE maximal positive elements.
  function automatic int acc_width(input int data_size, input int matrix_size);
    return data_size + $clog2(matrix_size);
  endfunction

endpackage

// File: rtl/relu_argmax_head_relu_row.sv
// Combinational ReLU over one matrix row, zero-padded out to the accumulator width.
module relu_row #(
  parameter int MATRIX_SIZE = 16,
  parameter int DATA_SIZE   = 8,
  parameter int ACC_W       = 12
) (
  input  logic [0:MATRIX_SIZE-1][DATA_SIZE-1:0] row_i,
  output logic [0:MATRIX_SIZE-1][ACC_W-1:0]     relu_o
);

  // Surviving values are non-negative, so sign extension reduces to zero fill.
  for (genvar c = 0; c < MATRIX_SIZE; c++) begin : g_lane
    assign relu_o[c] = row_i[c][DATA_SIZE-1] ? '0
                     : {{(ACC_W-DATA_SIZE){1'b0}}, row_i[c]};
  end

endmodule

// File: rtl/relu_argmax_head.sv
// Classification head: snapshot matrix, ReLU + column pooling one row per cycle,
// then a sequential argmax over the first NUM_CLASSES column sums.
module relu_argmax_head
  import ecg_head_pkg::*;
#(
  parameter int MATRIX_SIZE = 16,
  parameter int DATA_SIZE   = 8,
  parameter int NUM_CLASSES = 5,
  parameter int ACC_W       = acc_width(DATA_SIZE, MATRIX_SIZE)
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    start,
  output logic                                                    busy,
  output logic                                                    done,
  input  logic signed [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1][DATA_SIZE-1:0] in_matrix,
  output logic [$clog2(MATRIX_SIZE)-1:0]                          class_idx,
  output logic signed [ACC_W-1:0]                                 class_score
);

  localparam int IW = $clog2(MATRIX_SIZE);

  state_e                                               state_q, state_d;
  logic [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1][DATA_SIZE-1:0] snap_q;
  logic [0:MATRIX_SIZE-1][ACC_W-1:0]                    acc_q, relu_v;
  logic [IW-1:0]                                        row_q, col_q, idx_q, idx_d, class_idx_q;
  logic signed [ACC_W-1:0]                              best_q, best_d, cand, class_score_q;
  logic                                                 last_row, last_col;

  assign last_row = (row_q == IW'(MATRIX_SIZE-1));
  assign last_col = (col_q == IW'(NUM_CLASSES-1));

  relu_row #(
    .MATRIX_SIZE(MATRIX_SIZE),
    .DATA_SIZE  (DATA_SIZE),
    .ACC_W      (ACC_W)
  ) u_relu (
    .row_i (snap_q[row_q]),
    .relu_o(relu_v)
  );

  // Strict compare keeps the lowest index on ties; col 0 seeds the search.
  always_comb begin
    cand   = $signed(acc_q[col_q]);
    best_d = best_q;
    idx_d  = idx_q;
    if (col_q == '0 || cand > best_q) begin
      best_d = cand;
      idx_d  = col_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = ACCUM;
      ACCUM:   if (last_row) state_d = ARGMAX;
      ARGMAX:  if (last_col) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    class_idx   = class_idx_q;
    class_score = class_score_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_q        <= '0;
      acc_q         <= '0;
      row_q         <= '0;
      col_q         <= '0;
      best_q        <= '0;
      idx_q         <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          snap_q <= in_matrix;
          acc_q  <= '0;
          row_q  <= '0;
        end
        ACCUM: begin
          for (int c = 0; c < MATRIX_SIZE; c++) acc_q[c] <= acc_q[c] + relu_v[c];
          row_q <= row_q + IW'(1);
          if (last_row) col_q <= '0;
        end
        ARGMAX: begin
          best_q <= best_d;
          idx_q  <= idx_d;
          col_q  <= col_q + IW'(1);
          if (last_col) begin
            class_idx_q   <= idx_d;
            class_score_q <= best_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/relu_argmax_head.md
# relu_argmax_head

Classification head directly downstream of the `linear` stage. On `start`, it captures the MATRIX_SIZE×MATRIX_SIZE signed output matrix and applies ReLU element-wise. It then sums each column over all rows (global pooling over tokens) and scans the first NUM_CLASSES column sums sequentially for the maximum. It reports the winning class index and its pooled score with a one-cycle `done` pulse, and drives the ECG class decision.

## Interface
- MATRIX_SIZE, 16, rows/columns of the input matrix
- DATA_SIZE, 8, signed element width
- NUM_CLASSES, 5, columns scored as classes (1..MATRIX_SIZE)
- ACC_W, DATA_SIZE+$clog2(MATRIX_SIZE), column-sum width (derived, signed)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; result valid
- in_matrix  in  signed [DATA_SIZE-1:0] [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1]  element [r][c]; sampled only on the accepting edge
- class_idx  out  [$clog2(MATRIX_SIZE)-1:0]  winning column index
- class_score  out  signed [ACC_W-1:0]  pooled sum of the winning column

## Operation
- States: IDLE, ACCUM, ARGMAX, DONE.
- IDLE: on `start`=1, snapshot `in_matrix` into an internal register, clear `acc[0..MATRIX_SIZE-1]`, set row=0, go to ACCUM. `start`=0 means stay.
- ACCUM: each edge does `acc[c] += relu(mat[row][c])` for all c in parallel, then row++. The edge with row=MATRIX_SIZE-1 goes to ARGMAX with col=0.
- relu(x) = x<0 ? 0 : x, sign-extended to ACC_W. No overflow is possible: max sum is MATRIX_SIZE·(2^(DATA_SIZE-1)-1).
- ARGMAX: at col=0, load best=acc[0] and idx=0. For col>0, replace best/idx only if acc[col] > best (strict), so ties resolve to the lowest index. The edge with col=NUM_CLASSES-1 writes `class_idx`/`class_score` and goes to DONE.
- DONE: `done`=1 for this cycle only. The next edge goes to IDLE.
- `class_idx`/`class_score` hold their value until the next result is written. Columns ≥ NUM_CLASSES are accumulated but never scored.
- `start` while busy, including in the DONE cycle, is ignored and never queued.
- Changes on `in_matrix` after the accepting edge have no effect.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream): state=IDLE, `busy`=0, `done`=0, `class_idx`=0, `class_score`=0, all acc and snapshot registers =0.
- Reset mid-operation aborts immediately. No `done` follows, and outputs return to 0.
- With `start` high in cycle 0 (IDLE):
  - ACCUM runs in cycles 1..MATRIX_SIZE.
  - ARGMAX runs in cycles MATRIX_SIZE+1..MATRIX_SIZE+NUM_CLASSES.
  - `done` is high in cycle MATRIX_SIZE+NUM_CLASSES+1, which is cycle 22 at defaults.
- `busy` is high in cycles 1..22 at defaults.
- The earliest next accept is cycle 23, giving a throughput of one matrix per 23 cycles.
- Outputs are registered. `class_idx`/`class_score` change on the edge that enters DONE, so they are stable whenever `done`=1.

## Structure
- Shared package `ecg_head_pkg`: state enum (IDLE, ACCUM, ARGMAX, DONE) and a function returning ACC_W from DATA_SIZE and MATRIX_SIZE.
- One natural sub-module, `relu_row`: combinational. It takes one MATRIX_SIZE-element row and returns MATRIX_SIZE ReLU'd values sign-extended to ACC_W. It is instantiated once and indexed by row.
- The top level holds the FSM, row/col counters, snapshot, accumulators and argmax registers.

## Test plan
- Reset check: assert reset mid-ACCUM (cycle 5). Required: `busy`=`done`=0 and outputs 0 immediately; no `done` appears in the following 30 cycles.
- All elements +1 except column 3 = +2. Required: `done` in cycle 22, `class_idx`=3, `class_score`=32.
- Column 1 all -128 and column 0 all +1, rest 0. Required: `class_idx`=0, `class_score`=16. This shows negatives are clipped, not summed.
- Columns 2 and 4 each sum to 100, rest 0. Required: `class_idx`=2 (tie goes to lowest index).
- Column 7 = +127 everywhere, columns 0..4 = 0. Required: `class_idx`=0, `class_score`=0, because column 7 is outside NUM_CLASSES.
- Handshake check:
  - Pulse `start` at cycles 0, 5 and 22. Required: only one `done`, in cycle 22.
  - Change `in_matrix` in cycle 3. Required: result unaffected.
  - Assert `start` in cycle 23 with new data. Required: second `done` in cycle 45 with the new result.
